// File: rtl/time_pkg.sv
// Shared types and constants for the MM:SS time keeper.
// The optional blink feature in time_keeper_ctrl is enabled with TIME_KEEPER_BLINK_EN.
package time_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;
    localparam logic [3:0] DIGIT_BLANK   = 4'hF;

    // True in either of the two edit states.
    function automatic logic is_set_mode(input state_e s);
        return (s == SET_MIN) || (s == SET_SEC);
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter that counts 00..59 and wraps to 00.
// carry_out flags an increment at 59 when carry_en allows it to propagate.
module bcd_mod60_counter
    import time_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic       carry_en,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       carry_out
);

    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic       at_max;

    // Next digit values: clear wins over increment.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        units_d = units_q;
        tens_d  = tens_q;
        at_max  = (units_q == BCD_MAX_UNITS) && (tens_q == BCD_MAX_TENS);
        if (clr) begin
            units_d = '0;
            tens_d  = '0;
        end else if (inc) begin
            if (units_q == BCD_MAX_UNITS) begin
                units_d = '0;
                tens_d  = (tens_q == BCD_MAX_TENS) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
        carry_out = inc && carry_en && at_max;
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign units = units_q;
    assign tens  = tens_q;

endmodule

// File: rtl/time_keeper_ctrl.sv
// MM:SS sequencer: run/stop/set FSM, seconds prescaler and BCD time counters.
// Define TIME_KEEPER_BLINK_EN to blank the edited digit pair on a blink cadence.
module time_keeper_ctrl
    import time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BLINK_TICKS   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       mode,
    input  logic       inc,
    input  logic       clear,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [1:0] state,
    output logic       wrap
);

    localparam int PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("TICKS_PER_SEC must be at least 2");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink
        $error("BLINK_TICKS must be at least 1");
    end

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 wrap_q, wrap_d;
    logic                 sec_tick;
    logic                 set_min_inc, set_sec_inc;
    logic                 sec_inc, min_inc;
    logic                 sec_carry, min_carry;
    logic [3:0]           sec_units, sec_tens, min_units, min_tens;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= STOP;
        else     state_q <= state_d;
    end

    // Next state; clear beats mode, mode beats start_stop.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = STOP;
        end else begin
            case (state_q)
                STOP:    if (mode) state_d = SET_MIN;
                         else if (start_stop) state_d = RUN;
                RUN:     if (start_stop) state_d = STOP;
                SET_MIN: if (mode) state_d = SET_SEC;
                SET_SEC: if (mode) state_d = STOP;
                default: state_d = STOP;
            endcase
        end
    end

    // Prescaler, edit increments and wrap detection.
    always_comb begin
        sec_tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
        set_min_inc = inc && !mode && (state_q == SET_MIN);
        set_sec_inc = inc && !mode && (state_q == SET_SEC);
        sec_inc     = sec_tick || set_sec_inc;
        min_inc     = sec_carry || set_min_inc;
        wrap_d      = min_carry && !clear;
        presc_d     = presc_q;
        if (clear || ((state_d == SET_MIN) && (state_q != SET_MIN))) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler and wrap-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    // Seconds carry into minutes only on a running tick, never during editing.
    bcd_mod60_counter u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .clr       (clear),
        .carry_en  (sec_tick),
        .units     (sec_units),
        .tens      (sec_tens),
        .carry_out (sec_carry)
    );

    bcd_mod60_counter u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .clr       (clear),
        .carry_en  (sec_tick),
        .units     (min_units),
        .tens      (min_tens),
        .carry_out (min_carry)
    );

`ifdef TIME_KEEPER_BLINK_EN
    localparam int BLINK_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    // Blink cadence: runs only while editing, restarts on each edit increment.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!is_set_mode(state_d) || set_min_inc || set_sec_inc) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (is_set_mode(state_q)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = !blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`endif

    // Output mapping, with the edited pair blanked during the off phase.
    always_comb begin
        state  = state_q;
        wrap   = wrap_q;
        digit1 = sec_units;
        digit2 = sec_tens;
        digit3 = min_units;
        digit4 = min_tens;
`ifdef TIME_KEEPER_BLINK_EN
        if (blink_q && (state_q == SET_MIN)) begin
            digit3 = DIGIT_BLANK;
            digit4 = DIGIT_BLANK;
        end
        if (blink_q && (state_q == SET_SEC)) begin
            digit1 = DIGIT_BLANK;
            digit2 = DIGIT_BLANK;
        end
`endif
    end

endmodule
